canny_accel_udiv_30ns_15ns_16_seq: RTL and testbench
====================================================

CANNY_ACCEL_UDIV_30NS_15NS_16_SEQ -- requirements
Module: canny_accel_udiv_30ns_15ns_16_seq

Interface
REQ-001 Parameters SHALL be ID = 1 (instance tag, no functional effect); din0_WIDTH = 30 (dividend); din1_WIDTH = 15 (divisor); dout_WIDTH = 16 (quotient).
REQ-002 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: synchronous, active-low reset.
REQ-004 Port ce, input, 1: clock enable; when low, every register holds its value.
REQ-005 Port in_valid, input, 1: a dividend/divisor pair is offered.
REQ-006 Port in_ready, output, 1: the block accepts a pair this cycle.
REQ-007 Port din0, input, 30: unsigned dividend.
REQ-008 Port din1, input, 15: unsigned divisor.
REQ-009 Port out_valid, output, 1: a result is presented.
REQ-010 Port out_ready, input, 1: the consumer takes the result.
REQ-011 Port quot, output, 16: unsigned quotient.
REQ-012 Port rem, output, 15: unsigned remainder.
REQ-013 Port dbz, output, 1: divide-by-zero flag for the presented result.
REQ-014 Port ovf, output, 1: quotient-overflow flag for the presented result.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY, DONE. Transitions SHALL occur only on cycles with ce=1.
REQ-016 in_ready SHALL be 1 only in IDLE. The block SHALL accept a pair when in_valid and in_ready are both 1, and it SHALL then move from IDLE to BUSY.
REQ-017 On accept, the block SHALL latch din0 and din1, load a 16-bit partial remainder with {2'b0, din0[29:16]}, and clear the 5-bit iteration counter.
REQ-018 In BUSY, each ce cycle SHALL perform one restoring step, i = 15 down to 0: r = {r[14:0], dividend[i]}; if r >= divisor then r = r - divisor and q[i] = 1, else q[i] = 0.
REQ-019 After the 16th step, the FSM SHALL move to DONE. out_valid SHALL assert exactly 17 ce-cycles after the accept edge, with constant latency for every operand value.
REQ-020 If divisor == 0, the result SHALL be quot = 16'hFFFF, rem = dividend[14:0], dbz = 1, ovf = 0.
REQ-021 If divisor != 0 and dividend[29:16] >= divisor, the result SHALL be quot = 16'hFFFF, rem = 15'h0, ovf = 1, dbz = 0.
REQ-022 Otherwise, quot and rem SHALL satisfy dividend = quot*divisor + rem with rem < divisor, and dbz = ovf = 0.
REQ-023 In DONE, out_valid SHALL be 1, and quot, rem, dbz and ovf SHALL stay stable until out_ready = 1 on a ce cycle. On that cycle the FSM SHALL return to IDLE.
REQ-024 The block SHALL have no throughput overlap: a new pair is accepted no earlier than the cycle after the DONE→IDLE handshake.
REQ-025 in_valid SHALL be ignored outside IDLE. out_ready SHALL be ignored outside DONE.
REQ-026 With ce = 0, in_ready and out_valid SHALL keep their registered values, but no handshake completes.

Reset
REQ-027 With reset_n = 0 at a rising clk edge, the block SHALL go to IDLE regardless of ce. It SHALL clear the counter, operands, partial remainder, quot, rem, dbz and ovf to 0. After reset, out_valid = 0 and in_ready = 1.
REQ-028 Reset in BUSY or DONE SHALL discard the operation in flight, and no result for it SHALL appear afterwards.

Structure
REQ-029 A shared package SHALL hold: the width constants (30/15/16), the FSM state enum (IDLE, BUSY, DONE), the iteration count constant 16, and the saturation value 16'hFFFF.
REQ-030 The block SHALL contain one natural sub-module, canny_accel_udiv_30ns_15ns_16_seq_step. It is the combinational single restoring step: inputs r, divisor, dividend bit; outputs next r, quotient bit. It is instantiated once and reused each cycle.
REQ-031 Target size is 120-400 RTL lines. The design SHALL contain no DSP or multiplier inference.

Verification
REQ-032 1000 / 7 accepted at cycle 0, out_ready = 1 -> out_valid at cycle 17 with quot = 142, rem = 6, dbz = 0, ovf = 0.
REQ-033 30'h3FFFFFFF / 15'h7FFF -> quot = 16'h8001, rem = 0, no flags. 500 / 0 -> quot = 16'hFFFF, rem = 500, dbz = 1.
REQ-034 30'h10000 / 1 -> ovf = 1, quot = 16'hFFFF, rem = 0. 30'hFFFF / 1 -> quot = 16'hFFFF, rem = 0, ovf = 0.
REQ-035 out_ready held low 10 cycles after out_valid -> outputs stable and in_ready = 0 throughout. Then out_ready = 1 -> in_ready = 1 on the next cycle, and a back-to-back pair is accepted.
REQ-036 ce low for 5 cycles mid-BUSY -> out_valid at cycle 22, with the correct result.
REQ-037 reset_n low at step 8 -> in_ready = 1 and out_valid = 0 the next cycle. A fresh 1000 / 7 then completes correctly.

Source files
------------

// File: rtl/canny_accel_udiv_30ns_15ns_16_seq_pkg.sv
// Shared constants and types for the sequential 30/15 -> 16 unsigned divider.
//   Widths: 30-bit dividend, 15-bit divisor, 16-bit quotient, 15-bit remainder.
//   The FSM state enum, the number of restoring steps and the saturation value.
package canny_accel_udiv_30ns_15ns_16_seq_pkg;

  localparam int unsigned Din0Width = 30;
  localparam int unsigned Din1Width = 15;
  localparam int unsigned DoutWidth = 16;
  localparam int unsigned NumIter   = 16;
  localparam int unsigned CntWidth  = 5;

  localparam logic [DoutWidth-1:0] QuotSat = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/canny_accel_udiv_30ns_15ns_16_seq_step.sv
// One combinational restoring-division step.
//   i_r       : partial remainder before the step (16 bits)
//   i_divisor : divisor (15 bits)
//   i_bit     : next dividend bit shifted in
//   o_r       : partial remainder after the step
//   o_q       : quotient bit produced by the step
module canny_accel_udiv_30ns_15ns_16_seq_step
  import canny_accel_udiv_30ns_15ns_16_seq_pkg::*;
(
  input  logic [DoutWidth-1:0] i_r,
  input  logic [Din1Width-1:0] i_divisor,
  input  logic                 i_bit,
  output logic [DoutWidth-1:0] o_r,
  output logic                 o_q
);

  logic [DoutWidth-1:0] w_shift;
  logic [DoutWidth-1:0] w_div;

  always_comb begin
    w_shift = {i_r[DoutWidth-2:0], i_bit};
    w_div   = DoutWidth'(i_divisor);
    // An MSB shifted out means the remainder already exceeds any 15-bit divisor.
    o_q     = i_r[DoutWidth-1] | (w_shift >= w_div);
    o_r     = o_q ? (w_shift - w_div) : w_shift;
  end

endmodule

// File: rtl/canny_accel_udiv_30ns_15ns_16_seq.sv
// Sequential unsigned divider: 30-bit dividend / 15-bit divisor -> 16-bit quotient,
// 15-bit remainder, one restoring step per enabled cycle, fixed 17-cycle latency.
//   clk, reset_n (sync, active low), ce (clock enable)
//   in_valid/in_ready, din0 (dividend), din1 (divisor): operand handshake
//   out_valid/out_ready, quot, rem, dbz (divide by zero), ovf (quotient overflow)
module canny_accel_udiv_30ns_15ns_16_seq
  import canny_accel_udiv_30ns_15ns_16_seq_pkg::*;
#(
  parameter int          ID         = 1,
  parameter int unsigned din0_WIDTH = Din0Width,
  parameter int unsigned din1_WIDTH = Din1Width,
  parameter int unsigned dout_WIDTH = DoutWidth
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz,
  output logic                  ovf
);

  // The datapath is built for the package widths only.
  if (din0_WIDTH != Din0Width || din1_WIDTH != Din1Width || dout_WIDTH != DoutWidth)
  begin : g_bad_width
    $error("canny_accel_udiv_30ns_15ns_16_seq: unsupported width parameters");
  end
  if (ID < 0) begin : g_bad_id
    $error("canny_accel_udiv_30ns_15ns_16_seq: ID must be non-negative");
  end

  state_e               r_state,    w_state_nxt;
  logic [Din0Width-1:0] r_dividend, w_dividend_nxt;
  logic [Din1Width-1:0] r_divisor,  w_divisor_nxt;
  logic [DoutWidth-1:0] r_part,     w_part_nxt;
  logic [DoutWidth-1:0] r_q,        w_q_nxt;
  logic [CntWidth-1:0]  r_cnt,      w_cnt_nxt;
  logic [DoutWidth-1:0] r_quot,     w_quot_nxt;
  logic [Din1Width-1:0] r_rem,      w_rem_nxt;
  logic                 r_dbz,      w_dbz_nxt;
  logic                 r_ovf,      w_ovf_nxt;

  logic [DoutWidth-1:0] w_lo;
  logic [3:0]           w_bit_idx;
  logic                 w_bit;
  logic [DoutWidth-1:0] w_step_r;
  logic                 w_step_q;
  logic                 w_div_zero;
  logic                 w_q_ovf;

  // Step k consumes dividend bit 15-k, i.e. the bitwise inverse of k.
  always_comb begin
    w_lo       = r_dividend[DoutWidth-1:0];
    w_bit_idx  = ~r_cnt[3:0];
    w_bit      = w_lo[w_bit_idx];
    w_div_zero = (r_divisor == '0);
    w_q_ovf    = ({1'b0, r_dividend[Din0Width-1:DoutWidth]} >= r_divisor);
  end

  canny_accel_udiv_30ns_15ns_16_seq_step u_step (
    .i_r       (r_part),
    .i_divisor (r_divisor),
    .i_bit     (w_bit),
    .o_r       (w_step_r),
    .o_q       (w_step_q)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_part_nxt     = r_part;
    w_q_nxt        = r_q;
    w_cnt_nxt      = r_cnt;
    w_quot_nxt     = r_quot;
    w_rem_nxt      = r_rem;
    w_dbz_nxt      = r_dbz;
    w_ovf_nxt      = r_ovf;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_dividend_nxt = din0;
          w_divisor_nxt  = din1;
          w_part_nxt     = {2'b00, din0[Din0Width-1:DoutWidth]};
          w_q_nxt        = '0;
          w_cnt_nxt      = '0;
          w_state_nxt    = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt != CntWidth'(NumIter)) begin
          w_part_nxt = w_step_r;
          w_q_nxt    = {r_q[DoutWidth-2:0], w_step_q};
          w_cnt_nxt  = r_cnt + CntWidth'(1);
        end else begin
          // Extra cycle after the last step resolves the special cases.
          w_state_nxt = StDone;
          if (w_div_zero) begin
            w_quot_nxt = QuotSat;
            w_rem_nxt  = r_dividend[Din1Width-1:0];
            w_dbz_nxt  = 1'b1;
            w_ovf_nxt  = 1'b0;
          end else if (w_q_ovf) begin
            w_quot_nxt = QuotSat;
            w_rem_nxt  = '0;
            w_dbz_nxt  = 1'b0;
            w_ovf_nxt  = 1'b1;
          end else begin
            w_quot_nxt = r_q;
            w_rem_nxt  = r_part[Din1Width-1:0];
            w_dbz_nxt  = 1'b0;
            w_ovf_nxt  = 1'b0;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_part     <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (ce) begin
      r_state    <= w_state_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_part     <= w_part_nxt;
      r_q        <= w_q_nxt;
      r_cnt      <= w_cnt_nxt;
      r_quot     <= w_quot_nxt;
      r_rem      <= w_rem_nxt;
      r_dbz      <= w_dbz_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    quot      = r_quot;
    rem       = r_rem;
    dbz       = r_dbz;
    ovf       = r_ovf;
  end

endmodule

// File: tb/tb_canny_accel_udiv_30ns_15ns_16_seq.sv
// Self-checking bench for the sequential 30/15 divider: directed cases, handshake
// stalls, clock-enable gaps, reset mid-operation and a few random operand pairs.
module tb_canny_accel_udiv_30ns_15ns_16_seq;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] din0;
  logic [14:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [14:0] rem;
  logic        dbz;
  logic        ovf;

  typedef struct {
    logic [15:0] q;
    logic [14:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  canny_accel_udiv_30ns_15ns_16_seq #(
    .ID         (1),
    .din0_WIDTH (30),
    .din1_WIDTH (15),
    .dout_WIDTH (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [29:0] a, input logic [14:0] d);
    exp_t e;
    if (d == 15'd0) begin
      e.q = 16'hFFFF; e.r = a[14:0]; e.dbz = 1'b1; e.ovf = 1'b0;
    end else if ({1'b0, a[29:16]} >= d) begin
      e.q = 16'hFFFF; e.r = 15'd0; e.dbz = 1'b0; e.ovf = 1'b1;
    end else begin
      e.q = 16'(a / 30'(d)); e.r = 15'(a % 30'(d)); e.dbz = 1'b0; e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [29:0] a, input logic [14:0] d, input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back(model(a, d));
    din0     = a;
    din1     = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge (cycle 'base' on entry) until out_valid.
  task automatic wait_valid(input int base, input int lat_exp, input string tag);
    int n;
    n = base;
    while (n < base + 40 && out_valid !== 1'b1) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat_exp));
  endtask

  task automatic finish_result(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_quot"}, 32'(quot), 32'(e.q));
      chk({tag, "_rem"}, 32'(rem), 32'(e.r));
      chk({tag, "_dbz"}, 32'(dbz), 32'(e.dbz));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    reset_n   = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = '0;
    din1      = '0;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // 1000 / 7 with out_ready held high throughout (ignored outside DONE)
    out_ready = 1'b1;
    start(30'd1000, 15'd7, "d1000_7");
    wait_valid(0, 17, "d1000_7");
    chk("d1000_7_quot_const", 32'(quot), 32'd142);
    chk("d1000_7_rem_const", 32'(rem), 32'd6);
    finish_result("d1000_7");

    start(30'h3FFFFFFF, 15'h7FFF, "dmax");
    wait_valid(0, 17, "dmax");
    chk("dmax_quot_const", 32'(quot), 32'h8001);
    finish_result("dmax");

    start(30'd500, 15'd0, "dbz");
    wait_valid(0, 17, "dbz");
    chk("dbz_rem_const", 32'(rem), 32'd500);
    finish_result("dbz");

    start(30'h10000, 15'd1, "ovf");
    wait_valid(0, 17, "ovf");
    chk("ovf_flag_const", 32'(ovf), 32'd1);
    finish_result("ovf");

    start(30'hFFFF, 15'd1, "nofl");
    wait_valid(0, 17, "nofl");
    chk("nofl_quot_const", 32'(quot), 32'hFFFF);
    finish_result("nofl");

    // Stall in DONE; in_valid held high with other operands must be ignored
    chk("stall_in_ready", 32'(in_ready), 32'd1);
    sb.push_back(model(30'd123456, 15'd99));
    din0     = 30'd123456;
    din1     = 15'd99;
    in_valid = 1'b1;
    tick();
    din0 = 30'h2AAAAAAA;
    din1 = 15'd3;
    wait_valid(0, 17, "stall");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready_low", 32'(in_ready), 32'd0);
      chk("stall_quot", 32'(quot), 32'(sb[0].q));
      chk("stall_rem", 32'(rem), 32'(sb[0].r));
    end
    // ce low blocks the handshake
    ce        = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("ce_low_no_hs", 32'(out_valid), 32'd1);
    ce        = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    finish_result("stall");
    // Back-to-back pair right after the handshake
    start(30'd77777, 15'd321, "b2b");
    wait_valid(0, 17, "b2b");
    finish_result("b2b");

    // ce low for 5 cycles mid-BUSY
    start(30'd1000, 15'd7, "cegap");
    for (int i = 0; i < 3; i++) tick();
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cegap_out_valid_low", 32'(out_valid), 32'd0);
      chk("cegap_in_ready_low", 32'(in_ready), 32'd0);
    end
    ce = 1'b1;
    wait_valid(8, 22, "cegap");
    finish_result("cegap");

    // Reset at step 8, with ce low to show reset ignores it
    start(30'd1000, 15'd7, "rstmid");
    for (int i = 0; i < 8; i++) tick();
    reset_n = 1'b0;
    ce      = 1'b0;
    tick();
    reset_n = 1'b1;
    ce      = 1'b1;
    void'(sb.pop_back());
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    chk("rstmid_no_result", 32'(seen), 32'd0);
    start(30'd1000, 15'd7, "rstfresh");
    wait_valid(0, 17, "rstfresh");
    finish_result("rstfresh");

    // Random operands
    for (int i = 0; i < 8; i++) begin
      logic [29:0] a;
      logic [14:0] d;
      a = 30'($urandom);
      d = (i % 2 == 0) ? 15'($urandom_range(1, 32767)) : 15'($urandom_range(0, 7));
      if (i % 2 == 0) a[29:16] = 14'($urandom_range(0, 32767) % 32'(d));
      start(a, d, "rnd");
      wait_valid(0, 17, "rnd");
      finish_result("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
